// File: rtl/aes_shiftmix_stage.sv
// AES round stage after SubBytes: ShiftRows on capture, then a column-serial
// MixColumns + AddRoundKey pass (one column per cycle), with valid/ready on both sides.
module aes_shiftmix_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] key_q, key_d;
  logic         last_q, last_d;
  logic [127:0] out_state_q, out_state_d;

  logic [31:0]  col_in, key_col, col_new;
  logic [127:0] work_upd;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 of a column (row 0) sits in the most significant position.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

  // Column datapath: read column col_q, transform it, write it back in place.
  always_comb begin
    col_in   = work_q[127:96];
    key_col  = key_q[127:96];
    unique case (col_q)
      2'd0: begin col_in = work_q[127:96]; key_col = key_q[127:96]; end
      2'd1: begin col_in = work_q[95:64];  key_col = key_q[95:64];  end
      2'd2: begin col_in = work_q[63:32];  key_col = key_q[63:32];  end
      2'd3: begin col_in = work_q[31:0];   key_col = key_q[31:0];   end
      default: ;
    endcase
    col_new  = (last_q ? col_in : mix_col(col_in)) ^ key_col;
    work_upd = work_q;
    unique case (col_q)
      2'd0: work_upd[127:96] = col_new;
      2'd1: work_upd[95:64]  = col_new;
      2'd2: work_upd[63:32]  = col_new;
      2'd3: work_upd[31:0]   = col_new;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    key_d       = key_q;
    last_d      = last_q;
    out_state_d = out_state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = shift_rows(in_state);
          key_d   = in_key;
          last_d  = in_last;
          col_d   = 2'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        work_d = work_upd;
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) begin
          out_state_d = work_upd;
          col_d       = 2'd0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= 2'd0;
      work_q      <= '0;
      key_q       <= '0;
      last_q      <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      key_q       <= key_d;
      last_q      <= last_d;
      out_state_q <= out_state_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_state = out_state_q;

endmodule

// File: tb/tb_aes_shiftmix_stage.sv
// Self-checking bench for aes_shiftmix_stage: byte-matrix AES round model with a
// scoreboard checked every output cycle, plus directed FIPS-197 vectors.
module tb_aes_shiftmix_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;

  aes_shiftmix_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] VecS   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VecK   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ExpR1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ExpMc  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] ExpLst = 128'h7445a32768e07e1f9be228c8344beee0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int acc_last = 0;
  int acc_prev = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Reference round on a 4x4 byte matrix: ShiftRows, MixColumns (unless last), AddRoundKey.
  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic last);
    logic [7:0] a[4][4];
    logic [7:0] b[4][4];
    logic [7:0] m;
    logic [127:0] res;
    int cf[4];
    cf = '{2, 3, 1, 1};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) a[r][c] = s[127 - 8 * (4 * c + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r][c] = a[r][(c + r) % 4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        m = 8'h00;
        for (int j = 0; j < 4; j++) m = m ^ gmul(8'(cf[(j - r + 4) % 4]), b[j][c]);
        res[127 - 8 * (4 * c + r) -: 8] = (last ? b[r][c] : m) ^ k[127 - 8 * (4 * c + r) -: 8];
      end
    end
    return res;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge rst) exp_q.delete();

  // Accept monitor: inputs are stable at the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(in_state, in_key, in_last));
      acc_cnt++;
      acc_prev = acc_last;
      acc_last = cyc + 1;
    end
  end

  // Compare process: every cycle with out_valid must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h required no output", out_state);
      end else begin
        check("scoreboard", out_state, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [127:0] s, input logic [127:0] k, input logic l);
    bit ok;
    bit rdy;
    int guard;
    ok = 1'b0;
    guard = 0;
    in_state = s;
    in_key   = k;
    in_last  = l;
    in_valid = 1'b1;
    while (!ok && guard < 50) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (rdy) ok = 1'b1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic wait_valid(input bit toggle, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (toggle) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_last  = 1'($urandom);
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", 128'(out_valid), 128'd0);
    check("drain_in_ready", 128'(in_ready), 128'd1);
  endtask

  task automatic run_vec(input string name, input logic [127:0] s, input logic [127:0] k,
                         input logic l, input logic [127:0] exp);
    int lat;
    accept(s, k, l);
    wait_valid(1'b0, lat);
    check({name, "_latency"}, 128'(lat), 128'd4);
    check({name, "_result"}, out_state, exp);
    drain();
  endtask

  initial begin
    int lat;
    int c0;
    int guard;

    check("model_pin_round1", model(VecS, VecK, 1'b0), ExpR1);
    check("model_pin_nokey", model(VecS, 128'd0, 1'b0), ExpMc);
    check("model_pin_last", model(VecS, VecK, 1'b1), ExpLst);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_state", out_state, 128'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);

    run_vec("round1", VecS, VecK, 1'b0, ExpR1);
    run_vec("nokey", VecS, 128'd0, 1'b0, ExpMc);
    run_vec("last", VecS, VecK, 1'b1, ExpLst);

    // Backpressure with input toggling during BUSY.
    accept(VecS, VecK, 1'b0);
    wait_valid(1'b1, lat);
    check("bp_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_state", out_state, ExpR1);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    drain();

    // Asynchronous reset between edges, two cycles into BUSY.
    accept(VecS, VecK, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_state", out_state, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", 128'(out_valid), 128'd0);
    run_vec("after_rst", VecS, VecK, 1'b0, ExpR1);

    // Back-to-back with in_valid held and out_ready high.
    out_ready = 1'b1;
    in_state  = VecS;
    in_key    = VecK;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    c0 = acc_cnt;
    guard = 0;
    while (acc_cnt == c0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    in_key = 128'd0;
    wait_valid(1'b0, lat);
    check("b2b_first_latency", 128'(lat), 128'd4);
    check("b2b_first_result", out_state, ExpR1);
    guard = 0;
    while (acc_cnt < c0 + 2 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_cnt - c0), 128'd2);
    check("b2b_spacing", 128'(acc_last - acc_prev), 128'd6);
    wait_valid(1'b0, lat);
    check("b2b_second_latency", 128'(lat), 128'd4);
    check("b2b_second_result", out_state, ExpMc);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_done_out_valid", 128'(out_valid), 128'd0);
    check("b2b_done_in_ready", 128'(in_ready), 128'd1);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
